// File: rtl/z80_bus_sequencer.sv
// Z80 bus-cycle sequencer: steps one bus cycle (fetch, memory or I/O access)
// through its T-states and decodes the pin-latch controls and active-low
// strobes from the current T-state and the captured cycle type. Also hands
// the bus over to an external master on BUSRQ.
//
// Handshake: a request is taken on a rising edge when req_valid and
// req_ready are both high; req_ready only rises in IDLE or in the final
// T-state of a cycle, never during reset and never while nBUSRQ is low.
module z80_bus_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_type,
  output logic       req_ready,
  input  logic       nWAIT,
  input  logic       nBUSRQ,
  output logic       nBUSACK,
  output logic       cycle_done,
  output logic       ctl_ab_we,
  output logic       ctl_ab_oe,
  output logic       ctl_rfsh_sel,
  output logic       ctl_db_we,
  output logic       ctl_db_pin_re,
  output logic       ctl_db_pin_oe,
  output logic       ctl_ctrl_oe,
  output logic       nM1,
  output logic       nMREQ,
  output logic       nIORQ,
  output logic       nRD,
  output logic       nWR,
  output logic       nRFSH
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_TWA    = 3'd3,
    S_TW     = 3'd4,
    S_T3     = 3'd5,
    S_T4     = 3'd6,
    S_BUSACK = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    TY_FETCH = 3'd0,
    TY_MEMRD = 3'd1,
    TY_MEMWR = 3'd2,
    TY_IORD  = 3'd3,
    TY_IOWR  = 3'd4
  } type_t;

  state_t state_q, state_d;
  type_t  type_q,  type_d;

  logic final_st;
  logic is_io;
  logic accept;

  // Fetch ends after T4; every other cycle type ends in T3.
  assign final_st = (state_q == S_T4) || ((state_q == S_T3) && (type_q != TY_FETCH));
  assign is_io    = (type_q == TY_IORD) || (type_q == TY_IOWR);

  assign cycle_done = final_st;
  assign req_ready  = !reset && nBUSRQ && ((state_q == S_IDLE) || final_st);
  assign accept     = req_valid && req_ready;

  // State and cycle-type registers; reset discards any cycle in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      type_q  <= TY_FETCH;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
    end
  end

  // Next-state: wait sampling leaving T2/TWA/TW, BUSRQ sampled at cycle boundaries.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    if ((state_q == S_IDLE) || final_st) begin
      if (accept) begin
        state_d = S_T1;
        // Reserved codes behave as a plain memory read.
        type_d  = (req_type > 3'd4) ? TY_MEMRD : type_t'(req_type);
      end else if (!nBUSRQ) begin
        state_d = S_BUSACK;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_T1:     state_d = S_T2;
        S_T2:     state_d = is_io ? S_TWA : (nWAIT ? S_T3 : S_TW);
        S_TWA:    state_d = nWAIT ? S_T3 : S_TW;
        S_TW:     state_d = nWAIT ? S_T3 : S_TW;
        S_T3:     state_d = S_T4;  // only a fetch reaches here non-final
        S_BUSACK: state_d = nBUSRQ ? S_IDLE : S_BUSACK;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode from T-state and captured cycle type.
  always_comb begin
    nBUSACK       = 1'b1;
    ctl_ab_we     = 1'b0;
    ctl_ab_oe     = 1'b1;
    ctl_rfsh_sel  = 1'b0;
    ctl_db_we     = 1'b0;
    ctl_db_pin_re = 1'b0;
    ctl_db_pin_oe = 1'b0;
    ctl_ctrl_oe   = 1'b1;
    nM1           = 1'b1;
    nMREQ         = 1'b1;
    nIORQ         = 1'b1;
    nRD           = 1'b1;
    nWR           = 1'b1;
    nRFSH         = 1'b1;
    case (state_q)
      S_T1: begin
        ctl_ab_we = 1'b1;
        case (type_q)
          TY_FETCH: begin nM1 = 1'b0; nMREQ = 1'b0; nRD = 1'b0; end
          TY_MEMRD: begin nMREQ = 1'b0; nRD = 1'b0; end
          TY_MEMWR: begin nMREQ = 1'b0; ctl_db_pin_oe = 1'b1; ctl_db_we = 1'b1; end
          TY_IOWR:  begin ctl_db_pin_oe = 1'b1; ctl_db_we = 1'b1; end
          default:  ;
        endcase
      end
      S_T2, S_TW: begin
        case (type_q)
          TY_FETCH: begin nM1 = 1'b0; nMREQ = 1'b0; nRD = 1'b0; end
          TY_MEMRD: begin nMREQ = 1'b0; nRD = 1'b0; end
          TY_MEMWR: begin nMREQ = 1'b0; nWR = 1'b0; ctl_db_pin_oe = 1'b1; end
          TY_IORD:  begin nIORQ = 1'b0; nRD = 1'b0; end
          TY_IOWR:  begin nIORQ = 1'b0; nWR = 1'b0; ctl_db_pin_oe = 1'b1; end
          default:  ;
        endcase
      end
      S_TWA: begin
        case (type_q)
          TY_IORD: begin nIORQ = 1'b0; nRD = 1'b0; end
          TY_IOWR: begin nIORQ = 1'b0; nWR = 1'b0; ctl_db_pin_oe = 1'b1; end
          default: ;
        endcase
      end
      S_T3: begin
        case (type_q)
          TY_FETCH: begin
            // Read data is latched while the refresh address goes out.
            ctl_db_pin_re = 1'b1;
            ctl_ab_we     = 1'b1;
            ctl_rfsh_sel  = 1'b1;
            nRFSH         = 1'b0;
            nMREQ         = 1'b0;
          end
          TY_MEMRD: begin nMREQ = 1'b0; nRD = 1'b0; ctl_db_pin_re = 1'b1; end
          TY_MEMWR: begin nMREQ = 1'b0; nWR = 1'b0; ctl_db_pin_oe = 1'b1; end
          TY_IORD:  begin nIORQ = 1'b0; nRD = 1'b0; ctl_db_pin_re = 1'b1; end
          TY_IOWR:  begin nIORQ = 1'b0; nWR = 1'b0; ctl_db_pin_oe = 1'b1; end
          default:  ;
        endcase
      end
      S_T4: begin
        ctl_rfsh_sel = 1'b1;
        nRFSH        = 1'b0;
        nMREQ        = 1'b0;
      end
      S_BUSACK: begin
        nBUSACK     = 1'b0;
        ctl_ab_oe   = 1'b0;
        ctl_ctrl_oe = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Bench for z80_bus_sequencer: a plan of T-states is built transaction by
// transaction from the bus-cycle rules (lengths, wait placement, BUSRQ
// hand-over), then replayed cycle by cycle with the expected pin outputs.
module tb_z80_bus_sequencer;

  localparam int PH_IDLE = 0;
  localparam int PH_T1   = 1;
  localparam int PH_T2   = 2;
  localparam int PH_TWA  = 3;
  localparam int PH_TW   = 4;
  localparam int PH_T3   = 5;
  localparam int PH_T4   = 6;
  localparam int PH_BA   = 7;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_type;
  logic       req_ready;
  logic       nWAIT;
  logic       nBUSRQ;
  logic       nBUSACK;
  logic       cycle_done;
  logic       ctl_ab_we, ctl_ab_oe, ctl_rfsh_sel, ctl_db_we;
  logic       ctl_db_pin_re, ctl_db_pin_oe, ctl_ctrl_oe;
  logic       nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;

  int n_compared;
  int n_mismatched;
  int slot_idx;

  typedef struct {
    int         ph;
    int         ty;
    logic       rv;
    logic [2:0] rt;
    logic       nw;
    logic       nb;
  } slot_t;

  slot_t plan[$];

  z80_bus_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_type      (req_type),
    .req_ready     (req_ready),
    .nWAIT         (nWAIT),
    .nBUSRQ        (nBUSRQ),
    .nBUSACK       (nBUSACK),
    .cycle_done    (cycle_done),
    .ctl_ab_we     (ctl_ab_we),
    .ctl_ab_oe     (ctl_ab_oe),
    .ctl_rfsh_sel  (ctl_rfsh_sel),
    .ctl_db_we     (ctl_db_we),
    .ctl_db_pin_re (ctl_db_pin_re),
    .ctl_db_pin_oe (ctl_db_pin_oe),
    .ctl_ctrl_oe   (ctl_ctrl_oe),
    .nM1           (nM1),
    .nMREQ         (nMREQ),
    .nIORQ         (nIORQ),
    .nRD           (nRD),
    .nWR           (nWR),
    .nRFSH         (nRFSH)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] got_vec;
  assign got_vec = {nBUSACK, cycle_done, ctl_ab_we, ctl_ab_oe, ctl_rfsh_sel,
                    ctl_db_we, ctl_db_pin_re, ctl_db_pin_oe, ctl_ctrl_oe,
                    nM1, nMREQ, nIORQ, nRD, nWR, nRFSH};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_final(input int ph, input int ty);
    return (ph == PH_T4) || ((ph == PH_T3) && (ty != 0));
  endfunction

  // Expected pins, written directly from the per-type strobe tables.
  function automatic logic [14:0] exp_out(input int ph, input int ty);
    logic nbusack, done, ab_we, ab_oe, rfsh, db_we, pin_re, pin_oe, ctrl_oe;
    logic m1, mreq, iorq, rd, wr, rfshn;
    logic in_t12w, in_t123w, in_io_act, in_t34;
    nbusack = 1'b1; ab_oe = 1'b1; ctrl_oe = 1'b1;
    rfsh = 1'b0; pin_oe = 1'b0;
    m1 = 1'b1; mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; rfshn = 1'b1;
    in_t12w   = (ph == PH_T1) || (ph == PH_T2) || (ph == PH_TW);
    in_t123w  = in_t12w || (ph == PH_T3);
    in_io_act = (ph == PH_T2) || (ph == PH_TWA) || (ph == PH_TW) || (ph == PH_T3);
    in_t34    = (ph == PH_T3) || (ph == PH_T4);
    if (ph == PH_BA) begin
      nbusack = 1'b0; ab_oe = 1'b0; ctrl_oe = 1'b0;
    end
    done   = is_final(ph, ty);
    ab_we  = (ph == PH_T1) || ((ph == PH_T3) && (ty == 0));
    db_we  = (ph == PH_T1) && ((ty == 2) || (ty == 4));
    pin_re = (ph == PH_T3) && ((ty == 0) || (ty == 1) || (ty == 3));
    case (ty)
      0: begin
        if (in_t12w) begin m1 = 1'b0; mreq = 1'b0; rd = 1'b0; end
        if (in_t34)  begin rfshn = 1'b0; mreq = 1'b0; rfsh = 1'b1; end
      end
      1: if (in_t123w) begin mreq = 1'b0; rd = 1'b0; end
      2: begin
        if (in_t123w) begin mreq = 1'b0; pin_oe = 1'b1; end
        if (in_t123w && (ph != PH_T1)) wr = 1'b0;
      end
      3: if (in_io_act) begin iorq = 1'b0; rd = 1'b0; end
      4: begin
        if (in_io_act) begin iorq = 1'b0; wr = 1'b0; end
        if (in_io_act || (ph == PH_T1)) pin_oe = 1'b1;
      end
      default: ;
    endcase
    return {nbusack, done, ab_we, ab_oe, rfsh, db_we, pin_re, pin_oe, ctrl_oe,
            m1, mreq, iorq, rd, wr, rfshn};
  endfunction

  // Driver: apply one T-state's inputs, check outputs mid-cycle, advance.
  task automatic do_slot(input int ph, input int ty, input logic rv, input logic [2:0] rt,
                         input logic nw, input logic nb, input logic rst);
    logic exp_ready;
    reset = rst; req_valid = rv; req_type = rt; nWAIT = nw; nBUSRQ = nb;
    @(negedge clk);
    exp_ready = !rst && nb && ((ph == PH_IDLE) || is_final(ph, ty));
    check_eq($sformatf("pins slot%0d ph%0d ty%0d", slot_idx, ph, ty),
             {1'b0, got_vec}, {1'b0, exp_out(ph, ty)});
    check_eq($sformatf("req_ready slot%0d ph%0d ty%0d", slot_idx, ph, ty),
             16'(req_ready), 16'(exp_ready));
    slot_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic add_slot(input int ph, input int ty, input logic rv, input logic [2:0] rt,
                          input logic nw, input logic nb);
    slot_t s;
    s.ph = ph; s.ty = ty; s.rv = rv; s.rt = rt; s.nw = nw; s.nb = nb;
    plan.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rtype();
    return 3'($urandom_range(0, 7));
  endfunction

  // Append one transaction: optional idle gap, optional bus hand-over,
  // then the T-states of the cycle with w wait states.
  task automatic add_txn(input int raw, input int w, input int gap, input int bl, input logic brv);
    int ty;
    int last;
    ty = (raw > 4) ? 1 : raw;
    for (int g = 0; g < gap; g++) add_slot(PH_IDLE, 0, 1'b0, rtype(), rbit(), 1'b1);
    if (bl > 0) begin
      last = plan.size() - 1;
      plan[last].nb = 1'b0;
      plan[last].rv = brv;
      plan[last].rt = 3'(raw);
      for (int j = 1; j <= bl; j++)
        add_slot(PH_BA, 0, rbit(), rtype(), rbit(), (j == bl) ? 1'b1 : 1'b0);
      add_slot(PH_IDLE, 0, 1'b0, 3'd0, rbit(), 1'b1);
    end
    last = plan.size() - 1;
    plan[last].rv = 1'b1;
    plan[last].rt = 3'(raw);
    plan[last].nb = 1'b1;
    add_slot(PH_T1, ty, rbit(), rtype(), rbit(), rbit());
    if (ty >= 3) begin
      // I/O always inserts TWA; nWAIT in T2 must not matter.
      add_slot(PH_T2, ty, rbit(), rtype(), rbit(), rbit());
      add_slot(PH_TWA, ty, rbit(), rtype(), (w > 0) ? 1'b0 : 1'b1, rbit());
    end else begin
      add_slot(PH_T2, ty, rbit(), rtype(), (w > 0) ? 1'b0 : 1'b1, rbit());
    end
    for (int j = 1; j <= w; j++)
      add_slot(PH_TW, ty, rbit(), rtype(), (j < w) ? 1'b0 : 1'b1, rbit());
    if (ty == 0) begin
      add_slot(PH_T3, ty, rbit(), rtype(), rbit(), rbit());
      add_slot(PH_T4, ty, 1'b0, rtype(), rbit(), 1'b1);
    end else begin
      add_slot(PH_T3, ty, 1'b0, rtype(), rbit(), 1'b1);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    slot_idx = 0;
    reset = 1'b1; req_valid = 1'b0; req_type = 3'd0; nWAIT = 1'b1; nBUSRQ = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, and req_ready held low during reset.
    do_slot(PH_IDLE, 0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    // Start a fetch, then reset it in T2: nothing of it may survive.
    do_slot(PH_IDLE, 0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    do_slot(PH_T1,   0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    do_slot(PH_T2,   0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    do_slot(PH_IDLE, 0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    do_slot(PH_IDLE, 0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

    // Directed transactions, then randomized ones.
    add_slot(PH_IDLE, 0, 1'b0, 3'd0, 1'b1, 1'b1);
    add_txn(0, 0, 0, 0, 1'b0);   // fetch, no wait
    add_txn(1, 2, 1, 0, 1'b0);   // mem rd, two waits
    add_txn(2, 0, 1, 0, 1'b0);   // mem wr
    add_txn(3, 0, 0, 0, 1'b0);   // io rd back-to-back
    add_txn(1, 0, 0, 0, 1'b0);   // mem rd
    add_txn(1, 0, 0, 2, 1'b1);   // BUSRQ at end of mem rd with request pending
    add_txn(7, 1, 0, 0, 1'b0);   // reserved type behaves as mem rd
    add_txn(4, 2, 0, 0, 1'b0);   // io wr with waits
    for (int t = 0; t < 60; t++) begin
      add_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
              rbit());
    end
    for (int g = 0; g < 3; g++) add_slot(PH_IDLE, 0, 1'b0, 3'd0, 1'b1, 1'b1);

    foreach (plan[i])
      do_slot(plan[i].ph, plan[i].ty, plan[i].rv, plan[i].rt, plan[i].nw, plan[i].nb, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/z80_bus_sequencer.md
# z80_bus_sequencer

Per-T-state controller for the Z80 address-pin and data-pin blocks. It accepts one bus-cycle request at a time: opcode fetch (M1), memory read, memory write, I/O read or I/O write. It steps the cycle through T1/T2/Tw/T3/T4 and drives the pin-latch controls and active-low bus strobes. It also handles external WAIT stretching and BUSRQ/BUSACK bus hand-over.

## Interface

Parameters: none.

- clk  in  1  T-clock; one rising edge = one T-state
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_type  in  3  000 fetch, 001 mem rd, 010 mem wr, 011 io rd, 100 io wr; 101-111 treated as mem rd
- req_ready  out  1  request accepted on this edge when req_valid=1
- nWAIT  in  1  active-low wait from pins
- nBUSRQ  in  1  active-low external bus request
- nBUSACK  out  1  active-low bus grant
- cycle_done  out  1  high during final T-state of every cycle
- ctl_ab_we  out  1  latch internal address into address pins
- ctl_ab_oe  out  1  drive address pins; 0 = tri-state
- ctl_rfsh_sel  out  1  address mux selects refresh address (IR)
- ctl_db_we  out  1  latch internal data into data-pin latch
- ctl_db_pin_re  out  1  latch data pins into data-pin latch
- ctl_db_pin_oe  out  1  drive data pins from latch
- ctl_ctrl_oe  out  1  drive strobe pins; 0 = tri-state
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  out  1 each  active-low strobes

## Operation

- States: IDLE, T1, T2, TWA, TW, T3, T4, BUSACK.
- req_type is captured into a type register on acceptance.
- Outputs are Moore-decoded from state and the type register. req_ready is combinational.
- req_ready = !reset & nBUSRQ & (state==IDLE | cycle_done).
  - Acceptance in the final T-state gives a back-to-back T1 on the next edge with no IDLE gap.
- Transitions:
  - IDLE/final state → T1 on accept.
  - Otherwise IDLE/final state → BUSACK if nBUSRQ=0, else IDLE.
  - BUSRQ has priority over a pending request.
- T1 → T2 always.
- T2:
  - I/O goes → TWA unconditionally (automatic wait).
  - Memory and fetch go → TW if nWAIT=0, else → T3.
- TWA → TW if nWAIT=0, else T3.
- TW → TW while nWAIT=0, else T3.
- T3 → T4 for fetch. For all other types, T3 is the final state (cycle_done=1).
- T4 is final for fetch (cycle_done=1).
- BUSACK → BUSACK while nBUSRQ=0, else IDLE.
- Per-type strobes; only the listed strobes are low, all others high:
  - Fetch:
    - T1, T2, TW: nM1, nMREQ, nRD low.
    - T3, T4: nM1/nRD high; nRFSH and nMREQ low; ctl_rfsh_sel=1.
  - Mem rd: nMREQ, nRD low in T1, T2, TW, T3.
  - Mem wr:
    - nMREQ low in T1, T2, TW, T3.
    - nWR low in T2, TW, T3.
    - ctl_db_pin_oe=1 in T1, T2, TW, T3.
  - IO rd / IO wr:
    - nIORQ and nRD (rd) or nWR (wr) low in T2, TWA, TW, T3.
    - IO wr: ctl_db_pin_oe=1 in T1, T2, TWA, TW, T3.
- ctl_ab_we pulses:
  - 1 in T1 for all types.
  - Additionally 1 in T3 for fetch (latches refresh address).
- ctl_db_we = 1 in T1 for mem wr and io wr.
- ctl_db_pin_re = 1 in T3 for fetch, mem rd and io rd.
- In BUSACK:
  - nBUSACK=0, ctl_ab_oe=0, ctl_ctrl_oe=0, ctl_db_pin_oe=0.
  - All strobe values high.
- Outside BUSACK: ctl_ab_oe=1, ctl_ctrl_oe=1.

## Timing

- Reset values (state IDLE):
  - All n* strobes 1; nBUSACK 1.
  - ctl_ab_oe 1, ctl_ctrl_oe 1.
  - All other ctl_* 0; cycle_done 0; req_ready 0.
- Reset asserted mid-cycle: state returns to IDLE on that edge and all outputs take reset values. The captured request is discarded with no cycle_done.
- Cycle length with W = number of TW states:
  - Fetch = 4+W.
  - Mem rd/wr = 3+W.
  - IO = 4+W (includes TWA).
- nWAIT is sampled only on edges leaving T2, TWA, TW. It is ignored in all other states.
- nBUSRQ is sampled only in IDLE and in the final T-state.
  - BUSACK is entered on the edge after sampling.
  - Release takes one edge: BUSACK → IDLE. No request is accepted in BUSACK.
- Simultaneous req_valid and nBUSRQ=0: bus is granted; request stays pending (req_ready=0).

## Test plan

- Reset mid-fetch: assert reset in T2 → next edge all strobes 1, nBUSACK 1, state IDLE, no cycle_done.
- Fetch, nWAIT=1: req_type=000 → nM1/nMREQ/nRD low T1-T2; ctl_db_pin_re=1 in T3; nRFSH low and ctl_rfsh_sel=1 in T3-T4; cycle_done in T4; 4 clocks total.
- Mem read with 2 waits: nWAIT=0 for two T2/TW samples → states T1,T2,TW,TW,T3; ctl_db_pin_re in T3; 5 clocks total.
- Back-to-back mem wr then io rd with req_valid held:
  - Mem wr: ctl_db_we in T1; nWR low T2-T3; ctl_db_pin_oe T1-T3.
  - Io rd follows with T1 immediately after T3; TWA present with nWAIT=1; 4 clocks.
- Bus request:
  - nBUSRQ=0 during a mem rd → cycle completes.
  - Next clock nBUSACK=0, ctl_ab_oe=0, ctl_ctrl_oe=0; req_ready=0 with req_valid=1.
  - Release nBUSRQ → IDLE, then T1 of the pending request.
- Illegal type: req_type=111 → identical waveform to mem rd.
